conv3x3_stream_engine: RTL and testbench

//  Parametrised 3x3 multi-channel convolution engine: accepts a raster-order pixel stream,

---
 rtl/conv3x3_stream_engine.sv | 183 ++++++++++++++++++
 tb/tb_conv3x3_stream_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conv3x3_stream_engine.sv
// Streaming 3x3 multi-channel convolution with two line buffers,
// a sliding window per input channel and a 3-stage MAC pipeline.
module conv3x3_stream_engine #(
    parameter int DW     = 8,
    parameter int IN_CH  = 3,
    parameter int OUT_CH = 3,
    parameter int WW     = 18,
    parameter int ACC_W  = 31,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    localparam int NW    = OUT_CH * IN_CH * 9,
    localparam int AW    = $clog2(NW),
    localparam int RW    = $clog2(IMG_H),
    localparam int CW    = $clog2(IMG_W)
) (
    input  logic                    clk,
    input  logic                    RESET,
    input  logic                    start,
    input  logic                    in_valid,
    input  logic [IN_CH*DW-1:0]     in_data,
    input  logic                    w_we,
    input  logic [AW-1:0]           w_addr,
    input  logic signed [WW-1:0]    w_data,
    output logic                    busy,
    output logic                    out_valid,
    output logic [OUT_CH*ACC_W-1:0] out_data,
    output logic [RW-1:0]           out_row,
    output logic [CW-1:0]           out_col,
    output logic                    frame_done
);

    localparam int PW = DW + WW + 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [1:0] fcnt;
    logic accept;

    logic [IN_CH*DW-1:0] lb0 [IMG_W];
    logic [IN_CH*DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] win [IN_CH][9];
    logic signed [WW-1:0] wt [NW];
    logic signed [PW-1:0] prod [OUT_CH][IN_CH][9];
    logic signed [ACC_W-1:0] acc [OUT_CH];

    logic v1, v2;
    logic [RW-1:0] r1, r2;
    logic [CW-1:0] c1, c2;

    // start and the first pixel may arrive in the same cycle
    assign accept = in_valid && (state == RUN || (state == IDLE && start));

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            row        <= '0;
            col        <= '0;
            fcnt       <= '0;
        end else begin
            frame_done <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end
                RUN: if (accept && row == ROW_LAST && col == COL_LAST) begin
                    state <= FLUSH;
                    fcnt  <= '0;
                end
                FLUSH: begin
                    fcnt <= fcnt + 2'd1;
                    if (fcnt == 2'd2) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
            if (accept) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end else begin
                    col <= col + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            for (int k = 0; k < IMG_W; k++) begin
                lb0[k] <= '0;
                lb1[k] <= '0;
            end
            for (int i = 0; i < IN_CH; i++)
                for (int t = 0; t < 9; t++)
                    win[i][t] <= '0;
            for (int k = 0; k < NW; k++)
                wt[k] <= '0;
            v1 <= 1'b0;
            r1 <= '0;
            c1 <= '0;
        end else begin
            if (w_we && !busy && w_addr < AW'(NW))
                wt[w_addr] <= w_data;
            v1 <= accept && row >= RW'(2) && col >= CW'(2);
            if (accept) begin
                r1     <= row - RW'(2);
                c1     <= col - CW'(2);
                lb0[col] <= in_data;
                lb1[col] <= lb0[col];
                // new right column: rows r-2, r-1, r from top to bottom
                for (int i = 0; i < IN_CH; i++) begin
                    for (int rr = 0; rr < 3; rr++) begin
                        win[i][3*rr]   <= win[i][3*rr+1];
                        win[i][3*rr+1] <= win[i][3*rr+2];
                    end
                    win[i][2] <= lb1[col][i*DW +: DW];
                    win[i][5] <= lb0[col][i*DW +: DW];
                    win[i][8] <= in_data[i*DW +: DW];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            for (int o = 0; o < OUT_CH; o++)
                for (int i = 0; i < IN_CH; i++)
                    for (int t = 0; t < 9; t++)
                        prod[o][i][t] <= '0;
            v2 <= 1'b0;
            r2 <= '0;
            c2 <= '0;
        end else begin
            for (int o = 0; o < OUT_CH; o++)
                for (int i = 0; i < IN_CH; i++)
                    for (int t = 0; t < 9; t++)
                        prod[o][i][t] <= PW'($signed({1'b0, win[i][t]}))
                                       * PW'(wt[(o*IN_CH+i)*9+t]);
            v2 <= v1;
            r2 <= r1;
            c2 <= c1;
        end
    end

    always_comb begin
        for (int o = 0; o < OUT_CH; o++) begin
            acc[o] = '0;
            for (int i = 0; i < IN_CH; i++)
                for (int t = 0; t < 9; t++)
                    acc[o] = acc[o] + ACC_W'(prod[o][i][t]);
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_row   <= '0;
            out_col   <= '0;
        end else begin
            out_valid <= v2;
            if (v2) begin
                out_row <= r2;
                out_col <= c2;
                for (int o = 0; o < OUT_CH; o++)
                    out_data[o*ACC_W +: ACC_W] <= acc[o];
            end
        end
    end

endmodule

// File: tb/tb_conv3x3_stream_engine.sv
// Scoreboard bench for conv3x3_stream_engine: a plain-arithmetic frame
// model queues expected results, a monitor pops them on every out_valid.
module tb_conv3x3_stream_engine;

    localparam int DW = 8, IN_CH = 3, OUT_CH = 3, WW = 18, ACC_W = 31;
    localparam int IMG_W = 28, IMG_H = 28;
    localparam int NW = OUT_CH * IN_CH * 9;
    localparam int AW = $clog2(NW), RW = $clog2(IMG_H), CW = $clog2(IMG_W);
    localparam int N_OUT = (IMG_W - 2) * (IMG_H - 2);

    logic clk = 1'b0;
    logic RESET = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic [IN_CH*DW-1:0] in_data = '0;
    logic w_we = 1'b0;
    logic [AW-1:0] w_addr = '0;
    logic signed [WW-1:0] w_data = '0;
    logic busy, out_valid, frame_done;
    logic [OUT_CH*ACC_W-1:0] out_data;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;

    conv3x3_stream_engine dut (
        .clk(clk), .RESET(RESET), .start(start), .in_valid(in_valid),
        .in_data(in_data), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .busy(busy), .out_valid(out_valid), .out_data(out_data),
        .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int row;
        int col;
        logic [OUT_CH*ACC_W-1:0] data;
        longint cyc;
    } exp_t;

    exp_t sbq[$];
    int wm [OUT_CH][IN_CH][9];
    int img [IMG_H][IMG_W][IN_CH];

    longint cyc = 0;
    int n_out = 0, n_fd = 0;
    longint fd_cyc = 0;
    int mon_checks = 0, mon_errors = 0;
    int st_checks = 0, st_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // convolution of the stored frame at window top-left (r0,c0)
    function automatic logic [OUT_CH*ACC_W-1:0] ref_window(int r0, int c0);
        logic [OUT_CH*ACC_W-1:0] d;
        longint s;
        d = '0;
        for (int oc = 0; oc < OUT_CH; oc++) begin
            s = 0;
            for (int ic = 0; ic < IN_CH; ic++)
                for (int dr = 0; dr < 3; dr++)
                    for (int dc = 0; dc < 3; dc++)
                        s += longint'(img[r0+dr][c0+dc][ic])
                           * longint'(wm[oc][ic][dr*3+dc]);
            d[oc*ACC_W +: ACC_W] = s[ACC_W-1:0];
        end
        return d;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            n_out++;
            mon_checks++;
            if (sbq.size() == 0) begin
                mon_errors++;
                $display("FAIL unexpected_out row=%0d col=%0d data=%h expected no output",
                         out_row, out_col, out_data);
            end else begin
                e = sbq.pop_front();
                if (out_data !== e.data || int'(out_row) != e.row
                    || int'(out_col) != e.col || cyc != e.cyc) begin
                    mon_errors++;
                    $display("FAIL result got r=%0d c=%0d d=%h cyc=%0d expected r=%0d c=%0d d=%h cyc=%0d",
                             out_row, out_col, out_data, cyc, e.row, e.col, e.data, e.cyc);
                end
            end
        end
        if (frame_done) begin
            n_fd++;
            fd_cyc = cyc;
        end
    end

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        st_checks++;
        if (!ok) begin
            st_errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk(busy == 1'b0, {tag, "_busy"}, busy, 0);
        chk(out_valid == 1'b0, {tag, "_out_valid"}, out_valid, 0);
        chk(out_data == '0, {tag, "_out_data"}, longint'(out_data[62:0]), 0);
        chk(out_row == '0 && out_col == '0, {tag, "_out_rowcol"}, out_row * 100 + out_col, 0);
        chk(frame_done == 1'b0, {tag, "_frame_done"}, frame_done, 0);
    endtask

    task automatic load_w(input int mode);
        for (int o = 0; o < OUT_CH; o++)
            for (int i = 0; i < IN_CH; i++)
                for (int t = 0; t < 9; t++) begin
                    case (mode)
                        0: wm[o][i][t] = 1;
                        1: wm[o][i][t] = (o == 0 && t == 4) ? 1 : 0;
                        2: wm[o][i][t] = -131072;
                        default: wm[o][i][t] = int'($urandom_range(0, 262143)) - 131072;
                    endcase
                    w_we = 1'b1;
                    w_addr = AW'((o * IN_CH + i) * 9 + t);
                    w_data = WW'(wm[o][i][t]);
                    tick();
                end
        w_we = 1'b0;
    endtask

    task automatic drive_pixel(input int r, input int c, input bit with_start);
        exp_t e;
        in_valid = 1'b1;
        start = with_start;
        for (int ic = 0; ic < IN_CH; ic++)
            in_data[ic*DW +: DW] = DW'(img[r][c][ic]);
        if (r >= 2 && c >= 2) begin
            e.row = r - 2;
            e.col = c - 2;
            e.data = ref_window(r - 2, c - 2);
            e.cyc = cyc + 3;
            sbq.push_back(e);
        end
        tick();
        in_valid = 1'b0;
        start = 1'b0;
        w_we = 1'b0;
    endtask

    task automatic run_frame(input int pmode, input bit gap, input bit same,
                             input bit disturb, input int abort_row);
        int o0, f0;
        longint last_cyc;
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                for (int ic = 0; ic < IN_CH; ic++)
                    case (pmode)
                        0: img[r][c][ic] = 1;
                        1: img[r][c][ic] = (ic == 0) ? (c + r * IMG_W) % 256 : 0;
                        2: img[r][c][ic] = 255;
                        default: img[r][c][ic] = int'($urandom_range(0, 255));
                    endcase
        o0 = n_out;
        f0 = n_fd;
        last_cyc = 0;
        if (!same) begin
            in_valid = 1'b1;
            in_data = IN_CH*DW'($urandom);
            tick();
            tick();
            in_valid = 1'b0;
            start = 1'b1;
            tick();
            start = 1'b0;
        end
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                if (r == abort_row && c == 5) begin
                    RESET = 1'b1;
                    #1;
                    check_zero_outputs("abort");
                    sbq.delete();
                    for (int o = 0; o < OUT_CH; o++)
                        for (int i = 0; i < IN_CH; i++)
                            for (int t = 0; t < 9; t++)
                                wm[o][i][t] = 0;
                    tick();
                    RESET = 1'b0;
                    repeat (10) tick();
                    chk(n_fd == f0, "abort_no_frame_done", n_fd - f0, 0);
                    return;
                end
                if (disturb && c == 7) begin
                    w_we = 1'b1;
                    w_addr = AW'($urandom_range(0, NW - 1));
                    w_data = WW'($urandom);
                end
                last_cyc = cyc;
                drive_pixel(r, c, (same && r == 0 && c == 0) || (disturb && c == 7));
                if (r == 0 && c == 0)
                    chk(busy == 1'b1, "busy_in_run", busy, 1);
                if (gap) begin
                    in_data = IN_CH*DW'($urandom);
                    tick();
                end
            end
        for (int k = 0; k < 20 && n_fd == f0; k++)
            tick();
        repeat (3) tick();
        chk(n_fd - f0 == 1, "frame_done_count", n_fd - f0, 1);
        chk(fd_cyc == last_cyc + 4, "frame_done_cycle", fd_cyc, last_cyc + 4);
        chk(n_out - o0 == N_OUT, "out_count", n_out - o0, N_OUT);
        chk(sbq.size() == 0, "queue_empty", sbq.size(), 0);
        chk(busy == 1'b0, "busy_after_frame", busy, 0);
    endtask

    initial begin
        #1;
        check_zero_outputs("reset");
        repeat (2) tick();
        RESET = 1'b0;
        tick();
        check_zero_outputs("post_reset");

        load_w(0);
        run_frame(0, 1'b0, 1'b0, 1'b0, -1);
        load_w(1);
        run_frame(1, 1'b0, 1'b1, 1'b0, -1);
        load_w(2);
        run_frame(2, 1'b0, 1'b0, 1'b0, -1);
        load_w(0);
        run_frame(0, 1'b1, 1'b0, 1'b0, -1);
        load_w(3);
        run_frame(3, 1'b0, 1'b0, 1'b0, 10);
        load_w(3);
        run_frame(3, 1'b0, 1'b0, 1'b0, -1);
        load_w(3);
        run_frame(3, 1'b0, 1'b0, 1'b1, -1);
        repeat (5) tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 st_checks + mon_checks, st_errors + mon_errors);
        $finish;
    end

endmodule
